// File: rtl/pipe_pkg.sv
// Shared types and constants for the instruction fetch front end.
package pipe_pkg;

    localparam int INST_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    // One buffered fetch result: the instruction word and the address of
    // the instruction that follows it (what the IR stage needs for links).
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc4;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Sequential successor of a word-aligned PC; wraps naturally at 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/pipe_sync_fifo.sv
// Small synchronous FIFO with flush. The head entry is read straight from
// the storage registers, so it is stable whenever the FIFO is not written
// at the head slot.
module pipe_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage write; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy update; flush empties the FIFO in one cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pipe_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues pipelined in-order
// requests to instruction memory, buffers returned words and presents the
// head entry (instruction + PC+4) to the IF/ID register. A redirect flushes
// the buffer, reloads the PCs and arranges for in-flight stale words to be
// discarded as they come back.
//
// Handshakes:
//   imem request: a request transfers on a cycle where o_imem_req and
//   i_imem_gnt are both high; o_imem_addr is the address of that request.
//   imem response: each i_imem_rvalid pulse returns exactly one granted
//   request, in grant order, never in the grant cycle itself.
//   output: the head transfers on a cycle where o_out_valid and i_out_ready
//   are both high and no redirect is present; o_out_valid never depends on
//   i_out_ready.
module pipe_fetch_queue
    import pipe_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    output logic              o_imem_req,
    output logic [31:0]       o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [INST_W-1:0] i_imem_rdata,
    input  logic              i_redirect,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_out_valid,
    output logic [INST_W-1:0] o_out_inst,
    output logic [31:0]       o_out_pc4,
    input  logic              i_out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic          w_grant;
    logic          w_resp_accept;
    logic          w_pop;
    logic          w_credit;
    logic [CW:0]   w_inflight;
    logic [CW-1:0] w_count;
    logic          w_empty;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Every request either sits in memory or occupies a buffer slot, so the
    // sum bounds the space that could be demanded of the queue.
    assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_credit   = (w_inflight < (CW + 1)'(DEPTH));

    assign o_imem_req  = !i_reset && !i_redirect && w_credit;
    assign o_imem_addr = r_fetch_pc;

    assign w_grant       = o_imem_req && i_imem_gnt;
    // Words arriving while stale requests drain, or in a redirect cycle, are dropped.
    assign w_resp_accept = i_imem_rvalid && !i_redirect && (r_discard == '0);
    assign w_pop         = !w_empty && i_out_ready && !i_redirect;

    assign w_push_entry.inst = i_imem_rdata;
    assign w_push_entry.pc4  = next_pc(r_resp_pc);

    pipe_sync_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_flush (i_redirect),
        .i_push  (w_resp_accept),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign o_out_valid = !w_empty;
    assign o_out_inst  = w_empty ? NOP_INST : w_head.inst;
    assign o_out_pc4   = w_head.pc4;

    // Fetch PC: advances per granted request, reloaded on redirect.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_fetch_pc <= i_redirect_pc;
        end else if (w_grant) begin
            r_fetch_pc <= next_pc(r_fetch_pc);
        end
    end

    // Response PC: address of the next word expected to be kept.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_resp_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_resp_pc <= i_redirect_pc;
        end else if (w_resp_accept) begin
            r_resp_pc <= next_pc(r_resp_pc);
        end
    end

    // Requests granted but not yet returned (stale ones included).
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_grant, i_imem_rvalid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Stale responses still to be dropped. On redirect every request still in
    // flight after this cycle's response becomes stale; no grant can occur in
    // a redirect cycle, so that is outstanding minus this cycle's return.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_discard <= '0;
        end else if (i_redirect) begin
            r_discard <= r_outstanding - CW'(i_imem_rvalid);
        end else if (i_imem_rvalid && (r_discard != '0)) begin
            r_discard <= r_discard - CW'(1);
        end
    end

endmodule
